// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side event port of the PS/2 receiver: FWFT head, occupancy and pop request.
interface ps2_rx_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             rd_en;
   logic             code_valid;
   logic [9:0]       code_data;
   logic [CNT_W-1:0] fifo_count;

   modport master (output rd_en, input code_valid, code_data, fifo_count);
   modport slave  (input rd_en, output code_valid, code_data, fifo_count);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin filtering, 11-bit framing with parity/stop/timeout checks,
// E0/F0 prefix decoding into flagged events, an FWFT event FIFO and a raw byte history.
module ps2_rx_fifo #(
   parameter int FILT_LEN    = 8,
   parameter int TIMEOUT_CYC = 100000,
   parameter int FIFO_DEPTH  = 8,
   parameter int HIST_BYTES  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    kclk,
   input  logic                    kdata,
   input  logic                    clr_err,
   ps2_rx_fifo_if.slave            evt,
   output logic                    byte_stb,
   output logic                    frame_err,
   output logic                    err_sticky,
   output logic                    overflow,
   output logic [8*HIST_BYTES-1:0] keycode_hist
);
   localparam int FW = $clog2(FILT_LEN);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------------------------------------------------------------------
   // Input path: index 0 is kclk, index 1 is kdata.
   // ---------------------------------------------------------------------------
   logic [1:0]         sync1, sync2, filt;
   logic [1:0][FW-1:0] filt_cnt;
   logic               kclk_prev;
   logic               fall;
   logic               kdata_f;

   // NOTE: clocked state uses non-blocking assignments so every register samples
   // pre-edge values regardless of the order the statements are written in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= '1;
         sync2     <= '1;
         filt      <= '1;
         filt_cnt  <= '0;
         kclk_prev <= 1'b1;
      end else begin
         sync1     <= {kdata, kclk};
         sync2     <= sync1;
         kclk_prev <= filt[0];
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               filt_cnt[i] <= '0;
            end else if (filt_cnt[i] == FW'(FILT_LEN - 1)) begin
               filt[i]     <= sync2[i];
               filt_cnt[i] <= '0;
            end else begin
               filt_cnt[i] <= filt_cnt[i] + FW'(1);
            end
         end
      end
   end

   assign fall    = kclk_prev & ~filt[0];
   assign kdata_f = filt[1];

   // ---------------------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_q;
   logic          par_q;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          shift_en, par_en, bit_clr, frame_good, frame_bad;

   // A fall in the same cycle as expiry keeps the frame alive.
   assign tmo_hit = (state_q != S_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      shift_en   = 1'b0;
      par_en     = 1'b0;
      bit_clr    = 1'b0;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      if (tmo_hit) begin
         state_d   = S_IDLE;
         frame_bad = 1'b1;
      end else if (fall) begin
         unique case (state_q)
            S_IDLE: begin
               if (!kdata_f) begin
                  state_d = S_DATA;
                  bit_clr = 1'b1;
               end
            end
            S_DATA: begin
               shift_en = 1'b1;
               if (bit_idx == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_en  = 1'b1;
               state_d = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               if (kdata_f && ((^shift_q) ^ par_q)) frame_good = 1'b1;
               else                                 frame_bad  = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   logic [8*HIST_BYTES-1:0] hist_next;

   if (HIST_BYTES > 1) begin : g_hist
      assign hist_next = {keycode_hist[8*HIST_BYTES-9:0], shift_q};
   end else begin : g_hist1
      assign hist_next = shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         bit_idx      <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         tmo_cnt      <= '0;
         byte_stb     <= 1'b0;
         frame_err    <= 1'b0;
         keycode_hist <= '0;
      end else begin
         state_q   <= state_d;
         byte_stb  <= frame_good;
         frame_err <= frame_bad;
         if (state_d == S_IDLE || fall) tmo_cnt <= '0;
         else                           tmo_cnt <= tmo_cnt + TW'(1);
         if (bit_clr)       bit_idx <= '0;
         else if (shift_en) bit_idx <= bit_idx + 3'd1;
         if (shift_en)   shift_q      <= {kdata_f, shift_q[7:1]};
         if (par_en)     par_q        <= kdata_f;
         if (frame_good) keycode_hist <= hist_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Prefix decoder: the newest good byte is always keycode_hist[7:0].
   // ---------------------------------------------------------------------------
   logic ext_q, brk_q, is_e0, is_f0, push;

   assign is_e0 = (keycode_hist[7:0] == 8'hE0);
   assign is_f0 = (keycode_hist[7:0] == 8'hF0);
   assign push  = byte_stb && !is_e0 && !is_f0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (frame_err) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (byte_stb) begin
         if (is_e0) begin
            ext_q <= 1'b1;
         end else if (is_f0) begin
            brk_q <= 1'b1;
         end else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Event FIFO
   // ---------------------------------------------------------------------------
   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q;
   logic          valid, full, pop, wr;

   assign valid = (count_q != '0);
   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign pop   = evt.rd_en && valid;
   assign wr    = push && (!full || pop);

   // NOTE: the storage array is not reset; count_q alone says which entries are
   // live, and the output is gated to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= {ext_q, brk_q, keycode_hist[7:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow   <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (wr && !pop)      count_q <= count_q + CW'(1);
         else if (!wr && pop) count_q <= count_q - CW'(1);
         // Setting beats clearing in both sticky flags.
         overflow   <= (push && full && !pop) || (overflow && !clr_err);
         err_sticky <= frame_bad || frame_err || (err_sticky && !clr_err);
      end
   end

   assign evt.code_valid = valid;
   assign evt.code_data  = valid ? mem[rd_ptr] : 10'd0;
   assign evt.fifo_count = count_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed PS/2 frames plus a randomized run,
// compared against a byte-level reference model (event queue, flags, history).
module tb_ps2_rx_fifo;
   localparam int FILT_LEN    = 8;
   localparam int TIMEOUT_CYC = 400;
   localparam int FIFO_DEPTH  = 8;
   localparam int HIST_BYTES  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        kclk = 1'b1;
   logic        kdata = 1'b1;
   logic        clr_err = 1'b0;
   logic        byte_stb, frame_err, err_sticky, overflow;
   logic [31:0] keycode_hist;

   ps2_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) evt ();

   ps2_rx_fifo #(
      .FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC),
      .FIFO_DEPTH(FIFO_DEPTH), .HIST_BYTES(HIST_BYTES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata), .clr_err(clr_err),
      .evt(evt), .byte_stb(byte_stb), .frame_err(frame_err),
      .err_sticky(err_sticky), .overflow(overflow), .keycode_hist(keycode_hist)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [9:0]  mq[$];
   bit          m_ext, m_brk, m_ovf, m_sticky;
   logic [31:0] m_hist;

   int checks = 0;
   int errors = 0;
   int stb_cnt = 0;
   int err_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (byte_stb)  stb_cnt++;
         if (frame_err) err_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b, input int hp);
      kdata = b;
      cycles(hp);
      kclk = 1'b0;
      cycles(hp);
      kclk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int hp);
      logic par;
      par = (~^b) ^ bad_par;
      drive_bit(1'b0, hp);
      for (int i = 0; i < 8; i++) drive_bit(b[i], hp);
      drive_bit(par, hp);
      drive_bit(1'b1, hp);
      kdata = 1'b1;
      cycles(20);
   endtask

   task automatic model_frame(input logic [7:0] b, input bit good);
      if (good) begin
         m_hist = {m_hist[23:0], b};
         if (b == 8'hE0) m_ext = 1'b1;
         else if (b == 8'hF0) m_brk = 1'b1;
         else begin
            if (mq.size() < FIFO_DEPTH) mq.push_back({m_ext, m_brk, b});
            else m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
      end else begin
         m_ext = 1'b0;
         m_brk = 1'b0;
         m_sticky = 1'b1;
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ":count"}, evt.fifo_count, mq.size());
      check({tag, ":valid"}, evt.code_valid, mq.size() != 0);
      if (mq.size() != 0) check({tag, ":head"}, evt.code_data, mq[0]);
      check({tag, ":hist"}, keycode_hist, m_hist);
      check({tag, ":sticky"}, err_sticky, m_sticky);
      check({tag, ":ovf"}, overflow, m_ovf);
   endtask

   task automatic frame_checked(input string tag, input logic [7:0] b, input bit bad_par,
                                input int hp);
      int s0, e0;
      s0 = stb_cnt;
      e0 = err_cnt;
      send_frame(b, bad_par, hp);
      model_frame(b, !bad_par);
      check({tag, ":stb"}, stb_cnt - s0, !bad_par);
      check({tag, ":ferr"}, err_cnt - e0, bad_par);
      check_state(tag);
   endtask

   task automatic pop_one(input string tag);
      logic [9:0] e;
      e = mq.pop_front();
      check({tag, ":pop"}, evt.code_data, e);
      evt.rd_en = 1'b1;
      @(negedge clk);
      evt.rd_en = 1'b0;
   endtask

   task automatic wait_pulse(input bit on_err, output bit found);
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ((on_err ? frame_err : byte_stb) === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      m_sticky = 1'b0;
      m_ovf = 1'b0;
      cycles(2);
   endtask

   initial begin
      #800us;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int s0, e0;
      logic [7:0] b;

      evt.rd_en = 1'b0;
      m_ext = 0; m_brk = 0; m_ovf = 0; m_sticky = 0; m_hist = '0;

      // Reset state
      cycles(4);
      check("rst:valid", evt.code_valid, 0);
      check("rst:count", evt.fifo_count, 0);
      check("rst:data", evt.code_data, 0);
      check("rst:stb", byte_stb, 0);
      check("rst:ferr", frame_err, 0);
      check("rst:hist", keycode_hist, 0);
      check("rst:sticky", err_sticky, 0);
      check("rst:ovf", overflow, 0);
      rst_n = 1'b1;
      cycles(30);
      check("rst:no_spurious", stb_cnt + err_cnt, 0);

      // rd_en while empty is ignored
      evt.rd_en = 1'b1;
      cycles(1);
      evt.rd_en = 1'b0;
      cycles(1);
      check("empty_rd:count", evt.fifo_count, 0);
      check("empty_rd:ovf", overflow, 0);

      // Single 0x1C frame and event latency
      fork
         send_frame(8'h1C, 1'b0, 12);
         begin
            wait_pulse(1'b0, found);
            check("t1:stb_seen", found, 1);
            check("t1:valid_at_stb", evt.code_valid, 0);
            @(negedge clk);
            check("t1:valid_next", evt.code_valid, 1);
            check("t1:data", evt.code_data, 10'h01C);
         end
      join
      model_frame(8'h1C, 1'b1);
      check("t1:stb_once", stb_cnt, 1);
      check("t1:hist_lo", keycode_hist[7:0], 8'h1C);
      check_state("t1");
      pop_one("t1");
      check("t1:valid_after_pop", evt.code_valid, 0);

      // Extended break sequence, then flags cleared
      frame_checked("e0", 8'hE0, 1'b0, 12);
      frame_checked("f0", 8'hF0, 1'b0, 12);
      frame_checked("75", 8'h75, 1'b0, 12);
      check("ext_brk:data", evt.code_data, 10'h375);
      frame_checked("1c", 8'h1C, 1'b0, 12);
      pop_one("ext_brk");
      check("plain:data", evt.code_data, 10'h01C);
      pop_one("plain");

      // Parity error, sticky flag and clear
      frame_checked("par", 8'h1C, 1'b1, 12);
      check("par:sticky_set", err_sticky, 1);
      pulse_clr();
      check("par:sticky_clr", err_sticky, 0);

      // clr_err in the same cycle as a frame_err pulse: set wins
      s0 = err_cnt;
      fork
         send_frame(8'h33, 1'b1, 12);
         begin
            wait_pulse(1'b1, found);
            check("setwin:ferr_seen", found, 1);
            clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
         end
      join
      model_frame(8'h33, 1'b0);
      check("setwin:ferr", err_cnt - s0, 1);
      check_state("setwin");
      pulse_clr();

      // Timeout mid-frame after an E0 prefix; the prefix must be forgotten
      frame_checked("tmo_e0", 8'hE0, 1'b0, 12);
      s0 = stb_cnt;
      e0 = err_cnt;
      drive_bit(1'b0, 12);
      drive_bit(1'b0, 12);
      drive_bit(1'b0, 12);
      drive_bit(1'b1, 12);
      kdata = 1'b1;
      cycles(TIMEOUT_CYC + 10);
      model_frame(8'h00, 1'b0);
      check("tmo:ferr", err_cnt - e0, 1);
      check("tmo:stb", stb_cnt - s0, 0);
      frame_checked("tmo_1c", 8'h1C, 1'b0, 12);
      check("tmo:event", evt.code_data, 10'h01C);
      pop_one("tmo");
      pulse_clr();

      // Short kclk glitch in IDLE is filtered out; duplicates both reported
      s0 = stb_cnt;
      e0 = err_cnt;
      kdata = 1'b0;
      kclk = 1'b0;
      cycles(FILT_LEN - 2);
      kclk = 1'b1;
      kdata = 1'b1;
      cycles(20);
      check("glitch:pulses", (stb_cnt - s0) + (err_cnt - e0), 0);
      frame_checked("dup1", 8'h1C, 1'b0, 12);
      frame_checked("dup2", 8'h1C, 1'b0, 12);
      check("dup:count", evt.fifo_count, 2);
      pop_one("dup1");
      pop_one("dup2");

      // Fill past capacity
      for (int i = 0; i < FIFO_DEPTH + 1; i++)
         frame_checked("fill", 8'h10 + 8'(i), 1'b0, 12);
      check("fill:count", evt.fifo_count, FIFO_DEPTH);
      check("fill:ovf", overflow, 1);
      pulse_clr();
      check("fill:ovf_clr", overflow, 0);

      // Push and pop in the same cycle while full
      fork
         send_frame(8'h2A, 1'b0, 12);
         begin
            wait_pulse(1'b0, found);
            check("pp:stb_seen", found, 1);
            pop_one("pp");
         end
      join
      model_frame(8'h2A, 1'b1);
      check_state("pp");
      check("pp:count", evt.fifo_count, FIFO_DEPTH);
      while (mq.size() != 0) pop_one("drain");
      check("drain:valid", evt.code_valid, 0);

      // Randomized traffic
      for (int n = 0; n < 30; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         b = 8'($urandom);
         if (r == 0) b = 8'hE0;
         else if (r == 1) b = 8'hF0;
         frame_checked("rnd", b, $urandom_range(0, 7) == 0, int'($urandom_range(10, 20)));
         while (mq.size() != 0 && $urandom_range(0, 1) == 1) pop_one("rnd");
         if ($urandom_range(0, 5) == 0) pulse_clr();
      end
      while (mq.size() != 0) pop_one("rnd_drain");
      check_state("end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver, fully synchronous to the system clock. It synchronises and filters kclk/kdata, then frames each 11-bit packet with parity, stop and timeout checking. It decodes E0/F0 prefixes into flagged key events and buffers them in a FIFO for the game-control logic. It also keeps a raw byte-history shift register for seven-segment debug display.

Parameters:
FILT_LEN, 8, consecutive identical synchronised samples required before a filtered kclk/kdata level changes (>=2)
TIMEOUT_CYC, 100000, clk cycles without a filtered kclk falling edge that abort a frame in progress (1 ms at 100 MHz)
FIFO_DEPTH, 8, event FIFO entries; power of 2, >=2
HIST_BYTES, 4, bytes held in keycode_hist

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
kclk  in  1  PS/2 clock pin, asynchronous
kdata  in  1  PS/2 data pin, asynchronous
rd_en  in  1  pop request for head FIFO entry
clr_err  in  1  clears sticky flags
code_valid  out  1  FIFO not empty
code_data  out  10  head event {ext, brk, scancode[7:0]}, first-word-fall-through
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
byte_stb  out  1  one-cycle pulse per good byte
frame_err  out  1  one-cycle pulse on parity, stop or timeout error
err_sticky  out  1  latched frame_err
overflow  out  1  latched push-while-full
keycode_hist  out  8*HIST_BYTES  raw good bytes, newest in [7:0]

Behaviour:
- Reset (async assert, sync deassert to clk): all outputs, FIFO pointers, flags, FSM and history go to 0. Filter state goes to 1, so no spurious edge follows reset. Reset mid-frame discards the partial frame.
- Input path: 2-FF synchroniser per pin, then a filter. The filtered level takes the synchronised value only after FILT_LEN consecutive equal samples. A falling edge of filtered kclk (fall) samples filtered kdata.
- FSM IDLE: on fall, kdata=0 moves to DATA with bit index 0; kdata=1 (false start) stays in IDLE.
- FSM DATA: 8 falls capture LSB first; after bit 7, move to PARITY.
- FSM PARITY: capture the parity bit, move to STOP.
- FSM STOP: on fall, the frame is good if popcount(data)+parity is odd and stop=1. Always return to IDLE.
- Timeout: in any state other than IDLE, a counter counts cycles since the last fall and is reset by each fall. Reaching TIMEOUT_CYC returns the FSM to IDLE and pulses frame_err.
- Good byte: byte_stb pulses the cycle after the stop fall (latency 1), and keycode_hist shifts left 8 and inserts the byte. Repeated identical bytes are all reported; there is no de-duplication.
- Bad frame (parity, stop or timeout): no byte_stb, frame_err pulses for 1 cycle. Set of err_sticky beats clr_err when both occur in the same cycle.
- Decoder, on byte_stb:
  - 0xE0 sets ext and pushes nothing.
  - 0xF0 sets brk and pushes nothing.
  - Any other byte pushes {ext,brk,byte} and clears both flags.
  - frame_err clears both flags.
- Event latency: push occurs on the byte_stb cycle; code_valid is high the next cycle, i.e. 2 cycles after the stop fall.
- FIFO:
  - Pop when rd_en && code_valid; rd_en while empty is ignored.
  - Push while full with no pop: the event is dropped, overflow is set and contents are unchanged.
  - Simultaneous push and pop while full: both occur and fifo_count is unchanged.
  - Simultaneous push and pop while empty: only the push occurs.
  - Pointers wrap modulo FIFO_DEPTH.
  - overflow is cleared only by clr_err or reset; set wins over clear.

Test Plan:
- Frame start0, data 0x1C LSB-first, parity 0, stop 1, with kclk half-period 40 us -> byte_stb once, code_data=0x01C, fifo_count=1, keycode_hist[7:0]=0x1C. Then rd_en for 1 cycle -> code_valid=0.
- Bytes E0, F0, 75 -> exactly one event, 0x375. Next byte 0x1C -> event 0x01C (flags cleared).
- 0x1C with parity 1 -> no event, frame_err pulses once, err_sticky=1. clr_err -> err_sticky=0.
- Start bit plus 3 data bits, then idle for TIMEOUT_CYC+10 cycles, then a full 0x1C frame -> one frame_err, then event 0x01C.
- 9 make codes with no reads (FIFO_DEPTH=8) -> fifo_count=8, overflow=1, first 8 codes pop in order. Push+pop while full -> count stays 8.
- kclk low glitch of FILT_LEN-2 cycles while in IDLE -> no state change. Two identical 0x1C frames -> two events.
